// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and line levels, common to uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..BAUD_DIV-1 while enabled and flags the last cycle of each period.
// The tick is registered in lockstep with the counter, so it is high exactly when the count is BAUD_DIV-1.
module uart_baud_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, LSB-first serial frame with start, data, optional parity, stop.
// Define UART_TX_PARITY_EN for an 11-bit frame with parity; otherwise 8N1 and p_sel is ignored.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              p_sel,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              baud_tick
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    uart_state_e       state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              accept;
    logic              tick;

    assign accept = tx_valid && ready_q;

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (accept),
        .enable_i(state_q != IDLE),
        .tick_o  (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Parity is fixed at accept time because the data bits are shifted away during the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= (^tx_data) ^ p_sel;
        end
    end
`else
    logic unused_p_sel;
    assign unused_p_sel = p_sel;
`endif

    // NOTE: the shift register is reset too; it is a handful of flops, and a known value keeps the line clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= START;
                        shreg_q   <= tx_data;
                        bit_cnt_q <= '0;
                        tx_q      <= START_LEVEL;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_q   <= shreg_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= STOP_LEVEL;
`endif
                        end else begin
                            tx_q <= shreg_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        tx_q    <= STOP_LEVEL;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign baud_tick = tick;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line monitor decodes frames against a scoreboard of accepted bytes.
// Build with or without UART_TX_PARITY_EN to match the RTL configuration under test.
module tb_uart_tx;

    localparam int DIV = 16;
    localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         par;
    } frame_t;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data  = '0;
    logic         p_sel    = 1'b0;
    logic         tx_ready;
    logic         tx;
    logic         tx_busy;
    logic         baud_tick;

    int     n_checks    = 0;
    int     n_fail      = 0;
    int     frames_seen = 0;
    logic   mon_en      = 1'b0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(
        .BAUD_DIV(DIV),
        .DATA_W  (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .p_sel    (p_sel),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .baud_tick(baud_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line monitor: samples mid-bit after each falling start edge and scores the frame.
    initial begin : monitor
        logic [W-1:0] bits;
        logic         pbit;
        frame_t       e;
        bits = '0;
        pbit = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && reset && tx == 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                check("mon_start_bit", tx, 1'b0);
                for (int i = 0; i < W; i++) begin
                    repeat (DIV) @(negedge clk);
                    bits[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                pbit = tx;
`endif
                repeat (DIV) @(negedge clk);
                check("mon_stop_bit", tx, 1'b1);
                check("mon_frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("mon_data", bits, e.data);
`ifdef UART_TX_PARITY_EN
                    check("mon_parity", pbit, e.par);
`endif
                    frames_seen++;
                end
            end
        end
    end

    // Presents a byte, waits (bounded) for acceptance and returns at the first START-cycle negedge.
    task automatic send(input logic [W-1:0] d, input logic ps, input bit keep);
        int guard;
        guard = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        p_sel    = ps;
        while (tx_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready_wait", guard < 5000, 1'b1);
        exp_q.push_back(frame_t'{data: d, par: (^d) ^ ps});
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    // From the first START negedge, checks frame length, tick count and the return to idle.
    task automatic measure_frame(input string tag);
        int cycles;
        int ticks;
        cycles = 0;
        ticks  = 0;
        check({tag, "_busy_at_start"}, tx_busy, 1'b1);
        check({tag, "_line_at_start"}, tx, 1'b0);
        while (tx_ready !== 1'b1 && cycles < 4000) begin
            ticks += int'(baud_tick);
            @(negedge clk);
            cycles++;
        end
        check({tag, "_frame_clocks"}, cycles, NBITS * DIV);
        check({tag, "_baud_ticks"}, ticks, NBITS);
        check({tag, "_busy_at_end"}, tx_busy, 1'b0);
        check({tag, "_tick_in_idle"}, baud_tick, 1'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int bad;

        // Reset held for 10 clocks: outputs sit at their idle values throughout.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_ready", tx_ready, 1'b1);
            check("rst_busy", tx_busy, 1'b0);
            check("rst_tick", baud_tick, 1'b0);
        end
        reset  = 1'b1;
        mon_en = 1'b1;

        // Single frames, including parity-sensitive patterns.
        send(8'h55, 1'b1, 1'b0);
        measure_frame("f55_odd");
        send(8'h55, 1'b0, 1'b0);
        measure_frame("f55_even");
        send(8'h07, 1'b0, 1'b0);
        measure_frame("f07_even");
        send(8'h07, 1'b1, 1'b0);
        measure_frame("f07_odd");
        send(8'hFF, 1'b1, 1'b0);
        measure_frame("fFF_odd");
        send(8'hFF, 1'b0, 1'b0);
        measure_frame("fFF_even");

        // Back-to-back: valid held, second byte accepted the cycle tx_ready rises.
        send(8'hA5, 1'b0, 1'b1);
        tx_data = 8'h3C;
        measure_frame("b2b_first");
        exp_q.push_back(frame_t'{data: 8'h3C, par: (^8'h3C) ^ 1'b0});
        @(negedge clk);
        check("b2b_ready_dropped", tx_ready, 1'b0);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        p_sel    = 1'b1;
        measure_frame("b2b_second");

        // Reset pulsed during data bit 3 of 0xA2 (bit 3 is 0), frame abandoned.
        mon_en = 1'b0;
        send(8'hA2, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        repeat (4 * DIV + 5) @(negedge clk);
        check("midrst_line_before", tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_line_now", tx, 1'b1);
        check("midrst_ready_now", tx_ready, 1'b1);
        check("midrst_busy_now", tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || baud_tick !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        check("midrst_quiet_after", bad, 0);
        mon_en = 1'b1;
        send(8'hC3, 1'b1, 1'b0);
        measure_frame("after_rst");

        repeat (4) @(negedge clk);
        check("frames_scored", frames_seen, 9);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
